// File: rtl/addseq_ctrl.sv
// Multi-precision add/subtract sequencer: feeds one 16-bit limb per clock to an
// external fulladd16 slice, LSB limb first, rippling the carry through r_carry.
module addseq_ctrl #(
  parameter int WORDS = 4,
  parameter int IDXW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic                  c_in,
  input  logic [16*WORDS-1:0]   a_in,
  input  logic [16*WORDS-1:0]   b_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [16*WORDS-1:0]   sum_out,
  output logic                  c_out,
  output logic                  ovf,
  output logic [15:0]           add_a,
  output logic [15:0]           add_b,
  output logic                  add_cin,
  input  logic [15:0]           add_sum,
  input  logic                  add_cout
);

  localparam int W = 16 * WORDS;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_sum;
  logic [IDXW-1:0]   r_idx;
  logic              r_carry;
  logic              r_cout;
  logic              r_ovf;
  logic              w_accept;
  logic              w_last;
  logic [IDXW+3:0]   w_base;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_idx == LAST_IDX);
  assign w_base   = {r_idx, 4'd0};
  assign sum_out  = r_sum;
  assign c_out    = r_cout;
  assign ovf      = r_ovf;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RUN;
        else       w_next = S_IDLE;
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
        else        w_next = S_RUN;
      end
      S_DONE: begin
        if (start) w_next = S_RUN;
        else       w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (r_state)
      S_IDLE: ready = 1'b1;
      S_RUN:  busy  = 1'b1;
      S_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  // Adder drive: current limb while running, quiet zeros otherwise
  always_comb begin
    add_a   = 16'd0;
    add_b   = 16'd0;
    add_cin = 1'b0;
    if (r_state == S_RUN) begin
      add_a   = r_a[w_base +: 16];
      add_b   = r_b[w_base +: 16];
      add_cin = r_carry;
    end else begin
      add_a   = 16'd0;
      add_b   = 16'd0;
      add_cin = 1'b0;
    end
  end

  // Operand latch, limb capture, carry ripple and final flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= {W{1'b0}};
      r_b     <= {W{1'b0}};
      r_sum   <= {W{1'b0}};
      r_idx   <= {IDXW{1'b0}};
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1, so B is stored inverted and carry seeded with 1.
      r_a     <= a_in;
      r_b     <= op_sub ? ~b_in : b_in;
      r_idx   <= {IDXW{1'b0}};
      r_carry <= op_sub ? 1'b1 : c_in;
    end else if (r_state == S_RUN) begin
      r_sum[w_base +: 16] <= add_sum;
      if (w_last) begin
        r_cout <= add_cout;
        r_ovf  <= (r_a[W-1] == r_b[W-1]) && (add_sum[15] != r_a[W-1]);
      end else begin
        r_carry <= add_cout;
        r_idx   <= r_idx + {{(IDXW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_addseq_ctrl.sv
// Directed bench for addseq_ctrl with a behavioural fulladd16 and a result
// scoreboard fed at start and drained on every done pulse.
module tb_addseq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op_sub;
  logic        c_in;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] sum_out;
  logic        c_out;
  logic        ovf;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_sum;
  logic        add_cout;
  logic [16:0] w_full;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t q_exp[$];
  exp_t last_exp;
  int   total = 0;
  int   bad   = 0;

  addseq_ctrl #(.WORDS(4), .IDXW(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .c_in(c_in),
    .a_in(a_in), .b_in(b_in), .ready(ready), .busy(busy), .done(done),
    .sum_out(sum_out), .c_out(c_out), .ovf(ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // Behavioural fulladd16 slice
  assign w_full   = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
  assign add_sum  = w_full[15:0];
  assign add_cout = w_full[16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic sub, input logic cin);
    exp_t        e;
    logic [63:0] bb;
    logic [64:0] full;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {64'd0, (sub ? 1'b1 : cin)};
    e.sum  = full[63:0];
    e.cout = full[64];
    e.ovf  = (a[63] == bb[63]) && (full[63] != a[63]);
    return e;
  endfunction

  // Drive a request at the current (negedge) time and queue its expected result
  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic sub, input logic cin);
    exp_t e;
    start  = 1'b1;
    a_in   = a;
    b_in   = b;
    op_sub = sub;
    c_in   = cin;
    e = model(a, b, sub, cin);
    q_exp.push_back(e);
    last_exp = e;
  endtask

  // Count negedges until done (from the first negedge after the start edge)
  task automatic wait_done(input bit chk_cin, output int n);
    bit seen;
    seen = 1'b0;
    n    = 1;
    while (!seen && n < 20) begin
      if (done) seen = 1'b1;
      else begin
        if (chk_cin) chk("add_cin_each_limb", {63'd0, add_cin}, 64'd1);
        @(negedge clk);
        n++;
      end
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic sub, input logic cin, input bit chk_cin);
    int n;
    @(negedge clk);
    issue(a, b, sub, cin);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("ready_in_run", {63'd0, ready}, 64'd0);
    wait_done(chk_cin, n);
    chk("done_latency", 64'(n), 64'd5);
    @(negedge clk);
    chk("done_width", {63'd0, done}, 64'd0);
    chk("ready_idle", {63'd0, ready}, 64'd1);
    chk("sum_held", sum_out, last_exp.sum);
  endtask

  // Scoreboard drain on every done pulse
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q_exp.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        chk("sum_out", sum_out, e.sum);
        chk("c_out", {63'd0, c_out}, {63'd0, e.cout});
        chk("ovf", {63'd0, ovf}, {63'd0, e.ovf});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n  = 1'b0;
    start  = 1'b0;
    op_sub = 1'b0;
    c_in   = 1'b0;
    a_in   = 64'd0;
    b_in   = 64'd0;
    #12;
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_sum", sum_out, 64'd0);
    chk("rst_cout_ovf", {62'd0, c_out, ovf}, 64'd0);
    chk("idle_adder_drive", {31'd0, add_cin, add_a, add_b}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 1'b1);
    run_op(64'h5, 64'h7, 1'b1, 1'b1, 1'b0);
    run_op(64'h7, 64'h5, 1'b1, 1'b0, 1'b0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 1'b0);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1, 1'b0);

    // start during RUN is ignored
    @(negedge clk);
    issue(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    a_in   = 64'hDEAD_BEEF_DEAD_BEEF;
    b_in   = 64'h1111_1111_1111_1111;
    op_sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, n);
    chk("ignore_latency", 64'(n), 64'd3);
    @(negedge clk);
    chk("ignore_no_rerun", {63'd0, busy}, 64'd0);

    // back-to-back: start asserted in the DONE cycle
    issue(64'hFFFF, 64'h0001_0001, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, n);
    issue(64'h9, 64'h4, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    chk("b2b_done_low", {63'd0, done}, 64'd0);
    wait_done(1'b0, n);
    chk("b2b_second_done", 64'(n), 64'd5);
    @(negedge clk);

    // reset mid-operation at idx=1
    issue(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(q_exp.pop_back());
    chk("mid_rst_ready", {63'd0, ready}, 64'd1);
    chk("mid_rst_busy_done", {62'd0, busy, done}, 64'd0);
    chk("mid_rst_sum", sum_out, 64'd0);
    chk("mid_rst_flags", {62'd0, c_out, ovf}, 64'd0);
    chk("mid_rst_adder", {31'd0, add_cin, add_a, add_b}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {63'd0, ready}, 64'd1);
    run_op(64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(q_exp.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
